// File: rtl/gb_host_bridge.sv
// gb_host_bridge
//   Host-side ghostbus master. Turns a valid/ready command stream into a
//   single-cycle ghostbus transaction. Writes produce one `we` strobe and an
//   immediate ack. Reads hold `addr` and capture `dout` after RD_LAT cycles.
//   Every command gets exactly one response on a valid/ready response stream.
//
// Ports
//   clk, rst                  bus clock (rising edge); async active-high reset
//   cmd_valid/ready           command handshake (cmd_ready is registered)
//   cmd_we/addr/wdata         command fields, sampled only in the accept cycle
//   rsp_valid/ready           response handshake
//   rsp_we/rdata              response fields (rdata = 0 for write acks)
//   addr/din/we               ghostbus drive
//   dout                      ghostbus shared read-back
//   busy                      FSM not in IDLE
module gb_host_bridge #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] din,
    output logic          we,
    input  logic [DW-1:0] dout,
    output logic          busy
);

    generate
        if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
            $error("gb_host_bridge: RD_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT = 4'(RD_LAT);

    typedef enum logic [1:0] {IDLE, WSTB, RWAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       accept;

    assign accept = cmd_valid & cmd_ready;

    // Both strobes decode straight from the state register, so the async
    // reset drops them at once with no clock edge needed.
    assign we   = (state == WSTB);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = cmd_we ? WSTB : RWAIT;
            WSTB:                    state_nxt = RESP;
            RWAIT:   if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            addr      <= '0;
            din       <= '0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr      <= cmd_addr;
                        if (cmd_we) din <= cmd_wdata;  // reads leave din quiet
                        rsp_we    <= cmd_we;
                        cmd_ready <= 1'b0;
                        cnt       <= LAT;
                    end else begin
                        // Also the first edge after reset release.
                        cmd_ready <= 1'b1;
                    end
                end
                WSTB: begin
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                end
                RWAIT: begin
                    // addr first drove the bus in the cycle cnt == LAT; dout
                    // is valid once cnt has counted down to zero.
                    if (cnt == 4'd0) begin
                        rsp_rdata <= dout;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_host_bridge.sv
module tb_gb_host_bridge;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int RD_LAT = 2;

    logic          clk, rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, dout;
    logic          we, busy;

    // latency-only instances (RD_LAT=1 and RD_LAT=15) on a constant bus
    logic [1:0]    l_valid, l_cmd_ready, l_rsp_valid, l_rsp_we, l_we, l_busy;
    logic [DW-1:0] l_rdata [2];
    logic [AW-1:0] l_addr  [2];
    logic [DW-1:0] l_din   [2];
    logic          l_rsp_ready;
    logic [DW-1:0] l_dout;

    gb_host_bridge #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .addr(addr), .din(din), .we(we), .dout(dout),
        .busy(busy));

    gb_host_bridge #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .cmd_valid(l_valid[0]), .cmd_ready(l_cmd_ready[0]),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(l_rsp_valid[0]), .rsp_ready(l_rsp_ready), .rsp_we(l_rsp_we[0]),
        .rsp_rdata(l_rdata[0]), .addr(l_addr[0]), .din(l_din[0]), .we(l_we[0]),
        .dout(l_dout), .busy(l_busy[0]));

    gb_host_bridge #(.AW(AW), .DW(DW), .RD_LAT(15)) u_lat15 (
        .clk(clk), .rst(rst), .cmd_valid(l_valid[1]), .cmd_ready(l_cmd_ready[1]),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(l_rsp_valid[1]), .rsp_ready(l_rsp_ready), .rsp_we(l_rsp_we[1]),
        .rsp_rdata(l_rdata[1]), .addr(l_addr[1]), .din(l_din[1]), .we(l_we[1]),
        .dout(l_dout), .busy(l_busy[1]));

    assign l_dout = 32'hDEADBEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ghostbus slave model: write on strobe, read data RD_LAT cycles after addr
    logic [DW-1:0] mem [0:255] = '{default: '0};
    logic [AW-1:0] ap1, ap2;
    always @(posedge clk) begin
        if (we) mem[addr[7:0]] <= din;
        ap1 <= addr;
        ap2 <= ap1;
    end
    assign dout = mem[ap2[7:0]];

    // scoreboard
    typedef struct { bit w; logic [DW-1:0] rdata; int cyc; } exp_t;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    int we_cyc = -1, rdy_cyc = -1, last_hs = -100;
    logic [DW-1:0] last_din = '0;
    bit prev_v = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            chk("we_only_in_wstb", we, (cyc == we_cyc));
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    if (!prev_v) chk("rsp_first_cycle", cyc, q[0].cyc);
                    chk("rsp_we", rsp_we, q[0].w);
                    chk("rsp_rdata", rsp_rdata, q[0].rdata);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        last_hs = cyc;
                        rdy_cyc = cyc + 1;
                    end
                end
            end
            if (cyc == rdy_cyc) chk("cmd_ready_after_hs", cmd_ready, 1);
            prev_v = rsp_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input bit keep, input bit b2b);
        int t;
        bit ok;
        exp_t e;
        cmd_we = w; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1; ok = 1'b0; t = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; t = cyc; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
            cmd_valid = 1'b0;
            return;
        end
        e.w = w; e.rdata = w ? '0 : rd; e.cyc = t + 2 + (w ? 0 : RD_LAT);
        q.push_back(e);
        if (w) we_cyc = t + 1;
        if (b2b) chk("b2b_accept_cycle", t, last_hs + 1);
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
        chk("bus_addr", addr, a);
        chk("bus_din", din, w ? wd : last_din);
        if (w) last_din = wd;
    endtask

    task automatic wait_rsp_valid();
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) return;
            @(posedge clk); #1;
        end
        n_chk++; n_fail++;
        $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 100 cycles");
    endtask

    task automatic abort_cleanup();
        q.delete();
        we_cyc = -1; rdy_cyc = -1; last_din = '0;
        chk("addr_in_rst", addr, 0);
        chk("din_in_rst", din, 0);
        chk("cmd_ready_in_rst", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic lat_test(input int k, input int exp_lat);
        int t;
        bit ok;
        cmd_we = 1'b0; cmd_addr = 24'h000010; l_valid[k] = 1'b1; ok = 1'b0; t = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (l_cmd_ready[k]) begin ok = 1'b1; t = cyc; break; end
        end
        @(posedge clk); #1 l_valid[k] = 1'b0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL lat_accept_timeout: got no accept expected accept (inst %0d)", k);
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (l_rsp_valid[k]) begin ok = 1'b1; break; end
        end
        chk("lat_rsp_seen", ok, 1);
        chk("lat_cycles", cyc - t, exp_lat);
        chk("lat_rdata", l_rdata[k], 32'hDEADBEEF);
        chk("lat_rsp_we", l_rsp_we[k], 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; l_valid = '0; l_rsp_ready = 1'b1;

        // reset release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #2 chk("cmd_ready_before_edge", cmd_ready, 0);
        @(posedge clk); #1;
        chk("cmd_ready_after_release", cmd_ready, 1);

        // single write then read
        issue(1'b1, 24'h000040, 32'h5, '0, 1'b0, 1'b0);
        chk("busy_wstb", busy, 1);
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, 24'h000040, '0, 32'h5, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;

        // back-to-back with stalled responses
        rsp_ready = 1'b0;
        fork
            begin
                issue(1'b1, 24'h000080, 32'hA5A5A5A5, '0,           1'b1, 1'b0);
                issue(1'b0, 24'h000080, '0,           32'hA5A5A5A5, 1'b1, 1'b1);
                issue(1'b1, 24'h000084, 32'h000000FF, '0,           1'b1, 1'b1);
                issue(1'b0, 24'h000040, '0,           32'h5,        1'b0, 1'b1);
            end
            begin
                repeat (4) begin
                    wait_rsp_valid();
                    repeat (5) @(posedge clk);
                    #1 rsp_ready = 1'b1;
                    @(posedge clk);
                    #1 rsp_ready = 1'b0;
                end
            end
        join
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // reset during WSTB: aborted write must not land or retry
        issue(1'b1, 24'h000040, 32'h77, '0, 1'b0, 1'b0);
        chk("we_in_wstb", we, 1);
        #1 rst = 1'b1;
        #1;
        chk("we_async_drop", we, 0);
        chk("rsp_valid_async_wstb", rsp_valid, 0);
        abort_cleanup();
        issue(1'b0, 24'h000040, '0, 32'h5, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;

        // reset during RESP
        rsp_ready = 1'b0;
        issue(1'b0, 24'h000080, '0, 32'hA5A5A5A5, 1'b0, 1'b0);
        wait_rsp_valid();
        #1 rst = 1'b1;
        #1;
        chk("rsp_valid_async_resp", rsp_valid, 0);
        chk("busy_async_resp", busy, 0);
        rsp_ready = 1'b1;
        abort_cleanup();
        issue(1'b0, 24'h000084, '0, 32'h000000FF, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;

        // RD_LAT extremes
        lat_test(0, 3);
        lat_test(1, 17);

        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end
endmodule
